// File: rtl/fft_frame_feeder.sv
// Buffers 4-channel audio samples into FFT-sized frames and streams them out over AXI-Stream.
// Whole frames only: a write-side FSM finishes the current frame after enable_in drops, and each frame's last word carries tlast.
module fft_frame_feeder #(
    parameter int FRAME_LEN = 512,
    parameter int DEPTH     = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         enable_in,
    input  logic [63:0]  audio_data_in,
    input  logic         audio_valid_in,
    output logic         audio_ready_out,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    output logic         m_axis_tlast,
    input  logic         m_axis_tready,
    input  logic         clear_overflow_in,
    output logic         overflow_out,
    output logic [15:0]  frames_out
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [IW-1:0] widx;
    logic [64:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [64:0]   head;
    logic          full;
    logic          active;
    logic          wr;
    logic          drop;
    logic          rd;
    logic          load;

    // count covers the output register too, so "full" means DEPTH words held in total
    assign full            = (count == CW'(DEPTH));
    assign audio_ready_out = !full;

    // A DRAIN sitting on a frame boundary takes no new frame unless enable_in returns
    assign active = (state == RUN) || (state == DRAIN && (widx != '0 || enable_in));
    assign wr     = active && audio_valid_in && !full;
    assign drop   = active && audio_valid_in && full;
    assign rd     = m_axis_tvalid && m_axis_tready;
    assign load   = (count > CW'(m_axis_tvalid)) && (!m_axis_tvalid || m_axis_tready);
    assign head   = mem[rptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            widx         <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (wr) begin
                widx <= widx + 1'b1;
            end
            case (state)
                IDLE:  if (enable_in) state <= RUN;
                RUN:   if (!enable_in) state <= DRAIN;
                DRAIN: begin
                    if (enable_in) begin
                        state <= RUN;
                    end else if (widx == '0 || (wr && widx == LAST_IDX)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (drop) begin
                overflow_out <= 1'b1;
            end else if (clear_overflow_in) begin
                overflow_out <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; emptiness lives in the pointers and count,
    // and leaving it unreset keeps it mappable to RAM.
    always_ff @(posedge clk_in) begin
        if (wr) begin
            mem[wptr] <= {widx == LAST_IDX, audio_data_in};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (load) begin
                rptr <= rptr + 1'b1;
            end
            // NOTE: the explicit default keeps count holding on 00/11 with no implied latch-like gaps.
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= head[64];
                m_axis_tdata  <= {16'h0, head[63:48], 16'h0, head[47:32],
                                  16'h0, head[31:16], 16'h0, head[15:0]};
            end else if (rd) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            frames_out <= '0;
        end else if (rd && m_axis_tlast) begin
            frames_out <= frames_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with FRAME_LEN = 8, DEPTH = 4.
// Inputs change 1 time unit after the rising edge; outputs are captured on the falling edge.
module tb_fft_frame_feeder;

    localparam int FRAME_LEN = 8;
    localparam int DEPTH     = 4;

    logic         clk_in            = 1'b0;
    logic         rst_in            = 1'b0;
    logic         enable_in         = 1'b0;
    logic [63:0]  audio_data_in     = '0;
    logic         audio_valid_in    = 1'b0;
    logic         m_axis_tready     = 1'b0;
    logic         clear_overflow_in = 1'b0;
    logic         audio_ready_out;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         overflow_out;
    logic [15:0]  frames_out;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [128:0] got[$];
    logic         stall_prev = 1'b0;
    logic [127:0] prev_data  = '0;
    logic         prev_last  = 1'b0;

    always #5 clk_in = ~clk_in;

    fft_frame_feeder #(.FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .enable_in         (enable_in),
        .audio_data_in     (audio_data_in),
        .audio_valid_in    (audio_valid_in),
        .audio_ready_out   (audio_ready_out),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tready     (m_axis_tready),
        .clear_overflow_in (clear_overflow_in),
        .overflow_out      (overflow_out),
        .frames_out        (frames_out)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each channel gets a distinct offset so channel swaps show up; ch3 is negative.
    function automatic logic [63:0] sample(input int v);
        logic [15:0] b;
        b = 16'(v);
        return {16'h8000 | b, 16'h3000 + b, 16'h2000 + b, 16'h1000 + b};
    endfunction

    function automatic logic [127:0] word_of(input int v);
        logic [63:0] s;
        s = sample(v);
        return {16'h0, s[63:48], 16'h0, s[47:32], 16'h0, s[31:16], 16'h0, s[15:0]};
    endfunction

    // Output monitor: records handshakes and checks hold-stability after a stall.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_data", m_axis_tdata, prev_data);
                check("hold_last", 128'(m_axis_tlast), 128'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got.push_back({m_axis_tlast, m_axis_tdata});
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input int v, input bit wait_ready);
        if (wait_ready) begin
            int t = 0;
            while (!audio_ready_out && t < 50) begin
                cyc();
                t++;
            end
            check("send_ready", 128'(audio_ready_out), 128'(1));
        end
        audio_data_in  = sample(v);
        audio_valid_in = 1'b1;
        cyc();
        audio_valid_in = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int t = 0;
        while (got.size() < n && t < budget) begin
            cyc();
            t++;
        end
        check(tag, 128'(got.size()), 128'(n));
    endtask

    // Compares n captured words against values v0.. with tlast where the frame index wraps.
    task automatic check_words(input string tag, input int base, input int v0, input int n,
                               input int first_widx);
        for (int i = 0; i < n; i++) begin
            logic [128:0] w;
            w = (base + i < got.size()) ? got[base + i] : '0;
            check({tag, "_data"}, w[127:0], word_of(v0 + i));
            check({tag, "_last"}, 128'(w[128]),
                  128'(((first_widx + i) % FRAME_LEN) == FRAME_LEN - 1));
        end
    endtask

    task automatic do_reset();
        rst_in            = 1'b0;
        enable_in         = 1'b0;
        audio_valid_in    = 1'b0;
        clear_overflow_in = 1'b0;
        m_axis_tready     = 1'b0;
        cyc();
        cyc();
        rst_in = 1'b1;
        got.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_ready",    128'(audio_ready_out), 128'(1));
        check("rst_tvalid",   128'(m_axis_tvalid),   128'(0));
        check("rst_tlast",    128'(m_axis_tlast),    128'(0));
        check("rst_tdata",    m_axis_tdata,          128'(0));
        check("rst_frames",   128'(frames_out),      128'(0));
        check("rst_overflow", 128'(overflow_out),    128'(0));
        cyc();
        cyc();
        rst_in = 1'b1;

        // Two back-to-back frames, samples discarded while idle
        m_axis_tready = 1'b1;
        send(999, 0);
        cyc();
        cyc();
        check("idle_discard", 128'(got.size()),    128'(0));
        check("idle_tvalid",  128'(m_axis_tvalid), 128'(0));
        enable_in = 1'b1;
        cyc();
        for (int k = 0; k < 16; k++) begin
            audio_data_in  = sample(k);
            audio_valid_in = 1'b1;
            cyc();
            if (k == 0) check("lat_edge_n",  128'(m_axis_tvalid), 128'(0));
            if (k == 1) check("lat_edge_n1", 128'(m_axis_tvalid), 128'(1));
        end
        audio_valid_in = 1'b0;
        cyc();
        cyc();
        check("t1_count", 128'(got.size()), 128'(16));
        check_words("t1", 0, 0, 16, 0);
        check("t1_frames", 128'(frames_out), 128'(2));

        // Fill with sink stalled, overflow and clear priority, then resume mid-frame
        do_reset();
        enable_in = 1'b1;
        cyc();
        for (int k = 0; k < 6; k++) send(100 + k, 0);
        check("t2_ready_full", 128'(audio_ready_out), 128'(0));
        check("t2_overflow",   128'(overflow_out),    128'(1));
        clear_overflow_in = 1'b1;
        audio_data_in     = sample(150);
        audio_valid_in    = 1'b1;
        cyc();
        audio_valid_in = 1'b0;
        check("clr_vs_drop", 128'(overflow_out), 128'(1));
        cyc();
        clear_overflow_in = 1'b0;
        check("clr_alone", 128'(overflow_out), 128'(0));
        m_axis_tready = 1'b1;
        wait_words("t2_drain", 4, 10);
        check_words("t2a", 0, 100, 4, 0);
        for (int k = 0; k < 4; k++) send(200 + k, 1);
        wait_words("t2_tail", 8, 12);
        check_words("t2b", 4, 200, 4, 4);
        check("t2_frames", 128'(frames_out), 128'(1));

        // enable_in drops mid-frame: frame completes, then samples are discarded
        do_reset();
        enable_in     = 1'b1;
        m_axis_tready = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) send(300 + k, 1);
        enable_in = 1'b0;
        for (int k = 4; k < 11; k++) send(300 + k, 1);
        repeat (4) cyc();
        check("t3_count", 128'(got.size()), 128'(8));
        check_words("t3", 0, 300, 8, 0);
        check("t3_frames", 128'(frames_out), 128'(1));
        m_axis_tready = 1'b0;
        for (int k = 0; k < 6; k++) send(350 + k, 0);
        check("t3_idle_overflow", 128'(overflow_out),    128'(0));
        check("t3_idle_ready",    128'(audio_ready_out), 128'(1));

        // Sink toggling ready 1010...
        do_reset();
        enable_in     = 1'b1;
        m_axis_tready = 1'b1;
        cyc();
        fork
            begin
                for (int k = 0; k < 8; k++) send(400 + k, 1);
            end
            begin
                repeat (40) begin
                    cyc();
                    m_axis_tready = !m_axis_tready;
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_words("t4_count", 8, 10);
        check_words("t4", 0, 400, 8, 0);
        check("t4_frames", 128'(frames_out), 128'(1));

        // Reset in the middle of a frame
        do_reset();
        enable_in = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) send(500 + k, 0);
        check("t5_pre_tvalid",   128'(m_axis_tvalid), 128'(1));
        check("t5_pre_overflow", 128'(overflow_out),  128'(1));
        rst_in = 1'b0;
        #1;
        check("t5_rst_tvalid",   128'(m_axis_tvalid),   128'(0));
        check("t5_rst_tlast",    128'(m_axis_tlast),    128'(0));
        check("t5_rst_tdata",    m_axis_tdata,          128'(0));
        check("t5_rst_ready",    128'(audio_ready_out), 128'(1));
        check("t5_rst_overflow", 128'(overflow_out),    128'(0));
        check("t5_rst_frames",   128'(frames_out),      128'(0));
        cyc();
        rst_in = 1'b1;
        got.delete();
        m_axis_tready = 1'b1;
        cyc();
        for (int k = 0; k < 8; k++) send(600 + k, 1);
        wait_words("t5_count", 8, 10);
        check_words("t5", 0, 600, 8, 0);
        check("t5_frames", 128'(frames_out), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
